stage_fetch: RTL
================

STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-002 SHALL have port: clock  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: stall  in  1  hazard hold; freezes PC and the F/D outputs.
REQ-005 SHALL have port: ex_redirect  in  1  execute resolved a control transfer: taken bne/blt/bex, j, jal or jr.
REQ-006 SHALL have port: ex_target  in  32  next PC supplied by execute; valid only while ex_redirect=1.
REQ-007 SHALL have port: imem_addr  out  12  word address to the synchronous imem; data returns the next cycle.
REQ-008 SHALL have port: imem_data  in  32  imem read data for the address presented the previous cycle.
REQ-009 SHALL have port: fd_insn  out  32  instruction to decode.
REQ-010 SHALL have port: fd_pc_plus_1  out  32  PC+1 of fd_insn; bits [31:27] serve as the pc_upper_5 source.
REQ-011 SHALL have port: fd_valid  out  1  fd_insn is real; 0 means bubble.
REQ-012 SHALL have port: flush_dx  out  1  combinational copy of ex_redirect; squashes the D/X latch.

Function
REQ-013 SHALL hold internal registers: pc[31:0], req_pc[31:0], req_valid, skid_insn[31:0], skid_pc[31:0], skid_valid, and state in {RUN, HOLD}.
REQ-014 SHALL drive imem_addr = pc[11:0] combinationally; addresses wrap mod 4096 words.
REQ-015 SHALL, in RUN with stall=0 and ex_redirect=0, on each edge load: pc<=pc+1, req_pc<=pc, req_valid<=1, fd_insn<=imem_data, fd_pc_plus_1<=req_pc+1, fd_valid<=req_valid.
REQ-016 SHALL, in RUN with stall=1 and ex_redirect=0, hold pc and all fd_* outputs, capture skid_insn<=imem_data, skid_pc<=req_pc, skid_valid<=req_valid, and go to HOLD.
REQ-017 SHALL, in HOLD with stall=1 and ex_redirect=0, hold all registers.
REQ-018 SHALL, in HOLD with stall=0 and ex_redirect=0, load fd_insn<=skid_insn, fd_pc_plus_1<=skid_pc+1, fd_valid<=skid_valid, req_pc<=pc, req_valid<=1, pc<=pc+1, and go to RUN.
REQ-019 SHALL, whenever ex_redirect=1, in any state and regardless of stall, load pc<=ex_target, req_valid<=0, fd_valid<=0, skid_valid<=0, and go to RUN.
REQ-020 SHALL produce a redirect penalty of exactly 2 bubble cycles: fd_valid=0 on cycles r+1 and r+2, and fd_insn=mem[ex_target] with fd_valid=1 from cycle r+3.
REQ-021 SHALL drop no instruction and duplicate no instruction across any stall of any length.
REQ-022 SHALL perform PC arithmetic as 32-bit unsigned with wrap: 0xFFFFFFFF+1 = 0x00000000; fd_pc_plus_1 wraps the same way.
REQ-023 SHALL hold fd_insn and fd_pc_plus_1 at their last values whenever fd_valid=0.

Reset
REQ-024 SHALL, while reset=1, asynchronously force pc=0, req_pc=0, req_valid=0, skid_*=0, state=RUN, fd_insn=0, fd_pc_plus_1=0 and fd_valid=0.
REQ-025 SHALL present fd_insn=mem[0], fd_pc_plus_1=1 and fd_valid=1 after the second rising edge following reset deassertion.
REQ-026 SHALL let a reset that arrives mid-stall or mid-redirect discard all in-flight and skid state.

Structure
REQ-027 SHALL place the RUN/HOLD state encoding, IMEM_AW=12 and the NOP constant in the shared pipeline definitions package.
REQ-028 SHALL implement the skid register and its valid bit as one sub-module, fetch_skid.
REQ-029 SHALL generate PC+1 with the existing adder32, carry-in 0.

Verification
REQ-030 SHALL cover boot: imem[i]=0x100+i, reset then release -> fd_valid=0 for 1 cycle, then fd_insn 0x100, 0x101, ... with fd_pc_plus_1 = 1, 2, ....
REQ-031 SHALL cover a 3-cycle stall asserted while fd shows 0x103 -> fd holds 0x103 for 3 cycles, then 0x104, 0x105 with no gap or repeat.
REQ-032 SHALL cover ex_redirect=1, ex_target=0x40 for 1 cycle -> flush_dx=1 that cycle, fd_valid=0 for 2 cycles, then fd_insn=imem[0x40] with fd_pc_plus_1=0x41.
REQ-033 SHALL cover redirect to 0x20 with stall=1 in the same cycle, while in HOLD -> skid discarded, fd_valid=0 for 2 cycles, then imem[0x20].
REQ-034 SHALL cover redirect to 0xFFFFFFFF -> fd_pc_plus_1=0x00000000, imem_addr=0xFFF, and the next fetch is imem_addr=0x000.
REQ-035 SHALL cover reset asserted mid-HOLD -> all outputs 0 immediately; after release, the REQ-025 boot sequence.

Source files
------------

// File: rtl/stage_fetch_pkg.sv
// stage_fetch_pkg: shared pipeline definitions for the fetch stage.
package stage_fetch_pkg;
  localparam int IMEM_AW = 12;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic {RUN, HOLD} fetch_state_e;
endpackage

// File: rtl/adder32.sv
// adder32: 32-bit unsigned adder with carry-in; the sum wraps mod 2^32.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  assign sum = a + b + {31'b0, cin};
endmodule

// File: rtl/fetch_skid.sv
// fetch_skid: parks the instruction returned while fetch is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_insn,
  input  logic [31:0] d_pc,
  input  logic        d_valid,
  output logic [31:0] q_insn,
  output logic [31:0] q_pc,
  output logic        q_valid
);
  logic [31:0] insn_d, insn_q, pc_d, pc_q;
  logic        valid_d, valid_q;
  always_comb begin
    insn_d  = load ? d_insn : insn_q;
    pc_d    = load ? d_pc : pc_q;
    valid_d = clear ? 1'b0 : load ? d_valid : valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      insn_q  <= insn_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end
  assign q_insn  = insn_q;
  assign q_pc    = pc_q;
  assign q_valid = valid_q;
endmodule

// File: rtl/stage_fetch.sv
// stage_fetch: PC sequencing over a one-cycle synchronous imem with stall skid and redirect.
module stage_fetch
  import stage_fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               ex_redirect,
  input  logic [31:0]        ex_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        fd_insn,
  output logic [31:0]        fd_pc_plus_1,
  output logic               fd_valid,
  output logic               flush_dx
);
  fetch_state_e state_d, state_q;
  logic [31:0] pc_d, pc_q, req_pc_d, req_pc_q, fd_insn_d, fd_insn_q, fd_pc1_d, fd_pc1_q;
  logic        req_valid_d, req_valid_q, fd_valid_d, fd_valid_q;
  logic [31:0] pc_inc, fd_src, fd_inc, skid_insn, skid_pc;
  logic        skid_valid, skid_load, skid_clear;
  adder32 u_pc_inc (.a(pc_q), .b(32'd1), .cin(1'b0), .sum(pc_inc));
  adder32 u_fd_inc (.a(fd_src), .b(32'd1), .cin(1'b0), .sum(fd_inc));
  fetch_skid u_skid (
    .clk(clock), .rst(reset), .load(skid_load), .clear(skid_clear),
    .d_insn(imem_data), .d_pc(req_pc_q), .d_valid(req_valid_q),
    .q_insn(skid_insn), .q_pc(skid_pc), .q_valid(skid_valid)
  );
  // Leaving HOLD replays the parked instruction, otherwise the one just returned.
  assign fd_src = (state_q == HOLD) ? skid_pc : req_pc_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    fd_insn_d   = fd_insn_q;
    fd_pc1_d    = fd_pc1_q;
    fd_valid_d  = fd_valid_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    if (ex_redirect) begin
      state_d     = RUN;
      pc_d        = ex_target;
      req_valid_d = 1'b0;
      fd_valid_d  = 1'b0;
      skid_clear  = 1'b1;
    end else if (stall) begin
      skid_load = (state_q == RUN);
      state_d   = HOLD;
    end else begin
      state_d     = RUN;
      pc_d        = pc_inc;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      fd_insn_d   = (state_q == HOLD) ? skid_insn : imem_data;
      fd_pc1_d    = fd_inc;
      fd_valid_d  = (state_q == HOLD) ? skid_valid : req_valid_q;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= '0;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      fd_insn_q   <= NOP;
      fd_pc1_q    <= '0;
      fd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      fd_insn_q   <= fd_insn_d;
      fd_pc1_q    <= fd_pc1_d;
      fd_valid_q  <= fd_valid_d;
    end
  end
  assign imem_addr    = pc_q[IMEM_AW-1:0];
  assign fd_insn      = fd_insn_q;
  assign fd_pc_plus_1 = fd_pc1_q;
  assign fd_valid     = fd_valid_q;
  assign flush_dx     = ex_redirect;
endmodule
